// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage of the 5-stage MIPS
// pipeline: datapath widths, the NOP encoding, fetch FSM state codes, the
// {pc_4, instruction} buffer entry type and a wrapping PC+4 helper.
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int PC_W   = 12;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0000;

    // Fetch FSM state codes.
    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // One entry presented to IF/ID.
    typedef struct packed {
        logic [PC_W-1:0]   pc_4;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

    // Byte-address increment; wraps modulo 2^PC_W (12'hFFC + 4 = 12'h000).
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// -----------------------------------------------------------------------------
// fetch_skid_fifo
// Two-entry {pc_4, instruction} FIFO sitting between the ROM return path and
// the IF/ID register. Entry 0 is always the head, so the head outputs keep
// their last value once the FIFO drains. Same-cycle push and pop supported.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        flush all entries (priority over push/pop)
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          drop the head (ignored when empty)
//   head_o         current head entry
//   count_o        number of valid entries (0..2)
// -----------------------------------------------------------------------------
module fetch_skid_fifo
    import if_fetch_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            count_d = 2'd0;
        end else if (push_i && do_pop) begin
            if (count_q == 2'd2) begin
                head_d = tail_q;
                tail_d = push_data_i;
            end else begin
                head_d = push_data_i;
            end
        end else if (push_i) begin
            if (count_q == 2'd0) begin
                head_d = push_data_i;
            end else begin
                tail_d = push_data_i;
            end
            count_d = count_q + 2'd1;
        end else if (do_pop) begin
            if (count_q == 2'd2) begin
                head_d = tail_q;
            end
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the two storage entries are reset (not left X) because the
            // head is visible on pc_4/instruction and must read 0 after reset.
            head_q  <= '{pc_4: '0, insn: NOP_INSN};
            tail_q  <= '{pc_4: '0, insn: NOP_INSN};
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

    // The issue credit rule in the fetch unit keeps a push away from a full FIFO.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !clear_i && !do_pop && count_q == 2'd2))
        else $error("fetch_skid_fifo overflow");

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// IF stage: owns the PC, drives a 1-cycle synchronous-read instruction ROM
// and buffers returns in a 2-entry skid FIFO so a stall never loses an
// in-flight fetch. Handles branch/jump redirect and syscall halt.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   go_i             IF/ID accepts the presented head this cycle
//   redirect_i       taken branch/jump: flush and refetch from redirect_pc_i
//   redirect_pc_i    redirect target byte address (bits [1:0] = 0)
//   halt_i           syscall: stop fetching until reset
//   imem_en_o        ROM read strobe
//   imem_addr_o      ROM word address
//   imem_rdata_i     ROM data, valid the cycle after imem_en_o
//   pc_4_o           head entry fetch address + 4
//   instruction_o    head entry instruction
//   valid_o          head entry present
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              halt_i,
    output logic              imem_en_o,
    output logic [PC_W-3:0]   imem_addr_o,
    input  logic [INSN_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0]   pc_4_o,
    output logic [INSN_W-1:0] instruction_o,
    output logic              valid_o
);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;

    logic            fetching;
    logic            halt_now;
    logic            redirect_now;
    logic            pop;
    logic            can_issue;
    logic            fifo_clear;
    logic            fifo_push;
    logic [2:0]      occupancy;
    logic [1:0]      fifo_count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign fetching     = (state_q != ST_HALTED);
    assign halt_now     = halt_i && fetching;
    // Halt wins over a simultaneous redirect.
    assign redirect_now = redirect_i && fetching && !halt_i;
    // go is ignored in a redirect cycle: the head is being flushed anyway.
    assign pop          = valid_o && go_i && !redirect_i;

    // Entries that will occupy the FIFO next cycle without a new issue; a new
    // issue is only allowed if its return is guaranteed a free slot.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign can_issue = fetching && !halt_i && !redirect_now && (occupancy < 3'd2);

    // A redirect or halt makes both buffered entries and the return arriving
    // this cycle stale, so the push is suppressed along with the clear.
    assign fifo_clear = halt_now || redirect_now;
    assign fifo_push  = inflight_q && !fifo_clear;

    assign push_entry.pc_4 = pc_plus4(inflight_pc_q);
    assign push_entry.insn = imem_rdata_i;

    assign imem_en_o   = !rst_i && (redirect_now || can_issue);
    assign imem_addr_o = redirect_now ? redirect_pc_i[PC_W-1:2] : pc_q[PC_W-1:2];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end
        if (halt_now) begin
            state_d = ST_HALTED;
        end else if (redirect_now) begin
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_pc_i;
            pc_d          = pc_plus4(redirect_pc_i);
        end else if (can_issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_plus4(pc_q);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_skid_fifo u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (fifo_clear),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign valid_o       = (fifo_count != 2'd0);
    assign pc_4_o        = head.pc_4;
    assign instruction_o = head.insn;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Bench for if_fetch_unit: a ROM model returning 32'h1000_0000 + word address,
// a cycle table for start-up and stall, hand sequences for redirect, wrap,
// mid-stream reset and halt, and a scoreboard queue that checks every entry
// IF/ID accepts for order, loss and duplication.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt;
    logic              imem_en;
    logic [PC_W-3:0]   imem_addr;
    logic [INSN_W-1:0] imem_rdata = '0;
    logic [PC_W-1:0]   pc_4;
    logic [INSN_W-1:0] instruction;
    logic              valid;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_entry_t exp_q[$];

    if_fetch_unit #(.RESET_PC(12'h000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .go_i          (go),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .halt_i        (halt),
        .imem_en_o     (imem_en),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .pc_4_o        (pc_4),
        .instruction_o (instruction),
        .valid_o       (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [INSN_W-1:0] rom_word(input logic [PC_W-3:0] a);
        return 32'h1000_0000 + {22'b0, a};
    endfunction

    // Synchronous-read ROM, 1-cycle latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom_word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected accepted stream: sequential fetch from start_pc.
    task automatic sb_restart(input logic [PC_W-1:0] start_pc, input int n);
        logic [PC_W-1:0] p;
        fetch_entry_t    e;
        exp_q.delete();
        p = start_pc;
        for (int i = 0; i < n; i++) begin
            e.pc_4 = pc_plus4(p);
            e.insn = rom_word(p[PC_W-1:2]);
            exp_q.push_back(e);
            p = pc_plus4(p);
        end
    endtask

    // Scoreboard: every entry IF/ID accepts must be the next expected one.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (!rst && valid && go && !redirect && !halt) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: unexpected accept pc_4=%h instruction=%h", pc_4, instruction);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc_4", {20'b0, pc_4}, {20'b0, e.pc_4});
                check("sb_instruction", instruction, e.insn);
            end
        end
    end

    // One cycle: drive just after the rising edge, return at the falling edge.
    task automatic step(input logic g, input logic r, input logic [PC_W-1:0] rpc,
                        input logic h, input logic rs);
        @(posedge clk);
        #1;
        go          = g;
        redirect    = r;
        redirect_pc = rpc;
        halt        = h;
        rst         = rs;
        @(negedge clk);
    endtask

    typedef struct {
        logic            go;
        logic            exp_en;
        logic [PC_W-3:0] exp_addr;
        logic            exp_valid;
        logic [PC_W-1:0] exp_pc4;
        logic [31:0]     exp_insn;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Start-up with go=1, then a 3-cycle stall with head pc_4=00C.
        vecs[0]  = '{1'b1, 1'b1, 10'd0, 1'b0, 12'h000, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b1, 10'd1, 1'b0, 12'h000, 32'h0000_0000};
        vecs[2]  = '{1'b1, 1'b1, 10'd2, 1'b1, 12'h004, 32'h1000_0000};
        vecs[3]  = '{1'b1, 1'b1, 10'd3, 1'b1, 12'h008, 32'h1000_0001};
        vecs[4]  = '{1'b0, 1'b0, 10'd0, 1'b1, 12'h00C, 32'h1000_0002};
        vecs[5]  = '{1'b0, 1'b0, 10'd0, 1'b1, 12'h00C, 32'h1000_0002};
        vecs[6]  = '{1'b0, 1'b0, 10'd0, 1'b1, 12'h00C, 32'h1000_0002};
        vecs[7]  = '{1'b1, 1'b1, 10'd4, 1'b1, 12'h00C, 32'h1000_0002};
        vecs[8]  = '{1'b1, 1'b1, 10'd5, 1'b1, 12'h010, 32'h1000_0003};
        vecs[9]  = '{1'b1, 1'b1, 10'd6, 1'b1, 12'h014, 32'h1000_0004};
        vecs[10] = '{1'b1, 1'b1, 10'd7, 1'b1, 12'h018, 32'h1000_0005};

        rst = 1'b1; go = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

        // Reset state, observed during the second reset cycle.
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_pc_4", {20'b0, pc_4}, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_imem_en", {31'b0, imem_en}, 32'd0);
        sb_restart(12'h000, 64);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].go, 1'b0, 12'h000, 1'b0, 1'b0);
            check($sformatf("vec%0d_imem_en", i), {31'b0, imem_en}, {31'b0, vecs[i].exp_en});
            if (vecs[i].exp_en)
                check($sformatf("vec%0d_imem_addr", i), {22'b0, imem_addr}, {22'b0, vecs[i].exp_addr});
            check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_pc_4", i), {20'b0, pc_4}, {20'b0, vecs[i].exp_pc4});
            check($sformatf("vec%0d_instruction", i), instruction, vecs[i].exp_insn);
        end

        // Fill the buffer, then redirect to 0x200 while full and stalled.
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        check("full_imem_en", {31'b0, imem_en}, 32'd0);
        check("full_valid", {31'b0, valid}, 32'd1);
        check("full_pc_4", {20'b0, pc_4}, 32'h01C);
        step(1'b0, 1'b1, 12'h200, 1'b0, 1'b0);
        sb_restart(12'h200, 64);
        check("redir_imem_en", {31'b0, imem_en}, 32'd1);
        check("redir_imem_addr", {22'b0, imem_addr}, 32'h080);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check("redir_t1_valid", {31'b0, valid}, 32'd0);
        check("redir_t1_imem_addr", {22'b0, imem_addr}, 32'h081);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check("redir_t2_valid", {31'b0, valid}, 32'd1);
        check("redir_t2_pc_4", {20'b0, pc_4}, 32'h204);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);

        // Redirect mid-stream (return in flight) to 0xFF8: PC and address wrap.
        step(1'b1, 1'b1, 12'hFF8, 1'b0, 1'b0);
        sb_restart(12'hFF8, 64);
        check("wrap_t0_imem_addr", {22'b0, imem_addr}, 32'h3FE);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check("wrap_t1_valid", {31'b0, valid}, 32'd0);
        check("wrap_t1_imem_addr", {22'b0, imem_addr}, 32'h3FF);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check("wrap_t2_imem_addr", {22'b0, imem_addr}, 32'h000);
        check("wrap_t2_pc_4", {20'b0, pc_4}, 32'hFFC);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);

        // One-cycle reset mid-stream with a fetch in flight.
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        sb_restart(12'h000, 64);
        check("mrst_imem_en", {31'b0, imem_en}, 32'd0);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check("mrst_t1_valid", {31'b0, valid}, 32'd0);
        check("mrst_t1_imem_addr", {22'b0, imem_addr}, 32'h000);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check("mrst_t2_valid", {31'b0, valid}, 32'd0);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check("mrst_t3_valid", {31'b0, valid}, 32'd1);
        check("mrst_t3_pc_4", {20'b0, pc_4}, 32'h004);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);

        // Halt together with redirect: halt wins, later redirects are ignored.
        step(1'b0, 1'b1, 12'h100, 1'b1, 1'b0);
        exp_q.delete();
        check("halt_t0_imem_en", {31'b0, imem_en}, 32'd0);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, i[0], 12'h100, 1'b0, 1'b0);
            check($sformatf("halt_t%0d_imem_en", i), {31'b0, imem_en}, 32'd0);
            check($sformatf("halt_t%0d_valid", i), {31'b0, valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
